// File: rtl/cmos_nvram_pkg.sv
// Shared types and constants for the Williams2 CMOS NVRAM sequencer.
// Imported by the controller and available to anything that decodes its state.
package cmos_nvram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PAUSE,
    LOAD,
    SAVE,
    CLEAR,
    RELEASE
  } nv_state_t;

  typedef enum logic [1:0] {
    JOB_LOAD,
    JOB_SAVE,
    JOB_CLEAR
  } nv_job_t;

  // Upper nibble of every upload byte; the CMOS RAM is only 4 bits wide.
  localparam logic [3:0] NV_UPLOAD_PAD = 4'hF;

endpackage

// File: rtl/cmos_nvram_ctrl.sv
// Shares the single port of the 1K x 4 CMOS RAM between the game CPU and the
// HPS load/save/clear jobs, pausing the CPU while a job owns the port.
module cmos_nvram_ctrl
  import cmos_nvram_pkg::*;
#(
  parameter int         DEPTH        = 1024,
  parameter int         AW           = 10,
  parameter int         PAUSE_CYCLES = 16,
  parameter logic [3:0] CLEAR_VAL    = 4'h0
) (
  input  logic          clock_12,
  input  logic          reset,
  input  logic          dl_active,
  input  logic          ul_active,
  input  logic          ioctl_wr,
  input  logic          ioctl_rd,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  input  logic          clear_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [3:0]    cpu_wdata,
  output logic          cpu_pause,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [3:0]    ram_wdata,
  input  logic [3:0]    ram_rdata,
  output logic          busy,
  output logic          done
);

  localparam int              PCW        = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [PCW-1:0]  PAUSE_LOAD = PCW'(PAUSE_CYCLES - 1);
  localparam logic [AW:0]     DEPTH_W    = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR  = AW'(DEPTH - 1);

  nv_state_t      r_state, w_nextState;
  nv_job_t        r_job, w_nextJob;
  logic [PCW-1:0] r_pauseCnt;
  logic           r_pending;
  logic           r_clearPrev;
  logic           r_cpuPause;
  logic           r_done;
  logic           r_rdPend;
  logic           r_rdOor;
  logic [AW-1:0]  r_ramAddr;
  logic           r_ramWe;
  logic [3:0]     r_ramWdata;
  logic [7:0]     r_din;

  logic           w_clearRise;
  logic           w_inRange;
  logic           w_wrOk;
  logic           w_cpuOwns;
  logic           w_unused;

  assign w_clearRise = clear_req & ~r_clearPrev;
  assign w_inRange   = {1'b0, ioctl_addr} < DEPTH_W;
  assign w_wrOk      = ioctl_wr & w_inRange;
  assign w_unused    = ^ioctl_dout[7:4];

  always_ff @(posedge clock_12) begin
    if (reset) begin
      r_state <= IDLE;
      r_job   <= JOB_LOAD;
    end else begin
      r_state <= w_nextState;
      r_job   <= w_nextJob;
    end
  end

  // A strobe that arrives together with the dl_active fall keeps us in LOAD one
  // more cycle so it is written before RELEASE, which must never write.
  always_comb begin
    w_nextState = r_state;
    w_nextJob   = r_job;
    case (r_state)
      IDLE: begin
        if (dl_active) begin
          w_nextState = PAUSE;
          w_nextJob   = JOB_LOAD;
        end else if (ul_active) begin
          w_nextState = PAUSE;
          w_nextJob   = JOB_SAVE;
        end else if (r_pending) begin
          w_nextState = PAUSE;
          w_nextJob   = JOB_CLEAR;
        end
      end
      PAUSE: begin
        if (r_pauseCnt == '0) begin
          case (r_job)
            JOB_LOAD: w_nextState = LOAD;
            JOB_SAVE: w_nextState = SAVE;
            default:  w_nextState = CLEAR;
          endcase
        end
      end
      LOAD:    if (!dl_active && !w_wrOk) w_nextState = RELEASE;
      SAVE:    if (!ul_active) w_nextState = RELEASE;
      CLEAR:   if (r_ramAddr == LAST_ADDR) w_nextState = RELEASE;
      RELEASE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock_12) begin
    if (reset) begin
      r_pauseCnt  <= '0;
      r_pending   <= 1'b0;
      r_clearPrev <= clear_req;
      r_cpuPause  <= 1'b0;
      r_done      <= 1'b0;
      r_rdPend    <= 1'b0;
      r_rdOor     <= 1'b0;
      r_ramAddr   <= '0;
      r_ramWe     <= 1'b0;
      r_ramWdata  <= '0;
      r_din       <= 8'hFF;
    end else begin
      r_clearPrev <= clear_req;
      r_done      <= 1'b0;
      r_ramWe     <= 1'b0;
      r_rdPend    <= 1'b0;

      // A new edge wins over the start of a clear so it is not lost.
      if (w_clearRise)
        r_pending <= 1'b1;
      else if (r_state == PAUSE && w_nextState == CLEAR)
        r_pending <= 1'b0;

      if (r_state == IDLE && w_nextState == PAUSE) begin
        r_cpuPause <= 1'b1;
        r_pauseCnt <= PAUSE_LOAD;
      end else if (r_state == PAUSE) begin
        r_pauseCnt <= r_pauseCnt - 1'b1;
      end

      case (r_state)
        PAUSE: begin
          if (w_nextState == CLEAR) begin
            r_ramWe    <= 1'b1;
            r_ramAddr  <= '0;
            r_ramWdata <= CLEAR_VAL;
          end
        end
        LOAD: begin
          if (w_wrOk) begin
            r_ramWe    <= 1'b1;
            r_ramAddr  <= ioctl_addr;
            r_ramWdata <= ioctl_dout[3:0];
          end
        end
        SAVE: begin
          if (ioctl_rd) begin
            r_ramAddr <= ioctl_addr;
            r_rdPend  <= 1'b1;
            r_rdOor   <= ~w_inRange;
          end
        end
        CLEAR: begin
          if (w_nextState == CLEAR) begin
            r_ramWe   <= 1'b1;
            r_ramAddr <= r_ramAddr + 1'b1;
          end
        end
        RELEASE: begin
          r_done     <= 1'b1;
          r_cpuPause <= 1'b0;
        end
        default: ;
      endcase

      if (r_rdPend)
        r_din <= r_rdOor ? 8'hFF : {NV_UPLOAD_PAD, ram_rdata};
    end
  end

  // The CPU keeps the port through reset so its address path stays live,
  // but it cannot write until reset is released.
  assign w_cpuOwns = reset | (r_state == IDLE);
  assign ram_addr  = w_cpuOwns ? cpu_addr : r_ramAddr;
  assign ram_we    = w_cpuOwns ? (cpu_we & ~reset) : r_ramWe;
  assign ram_wdata = w_cpuOwns ? cpu_wdata : r_ramWdata;

  assign cpu_pause = r_cpuPause;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign ioctl_din = r_din;

endmodule
